// File: rtl/oclib_prbs.sv
`default_nettype none
// ============================================================================
// Module   : oclib_prbs
// Purpose  : PRBS generator and self-synchronising checker with a runtime
//            selectable polynomial (PRBS7/15/23/31), valid/ready output
//            handshake, HUNT/LOCKED lock tracking and a saturating error count.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock          : sole clock, rising edge
//   reset_n        : asynchronous active-low reset
//   mode[1:0]      : 0=PRBS7 1=PRBS15 2=PRBS23 3=PRBS31
//   gen_enable     : permits generation of new beats
//   gen_inject     : flips bit 0 of the beat loaded this cycle
//   gen_data       : generated beat, bit 0 earliest in time
//   gen_valid      : gen_data holds a beat
//   gen_ready      : consumer accepts gen_data
//   chk_data       : received beat to check
//   chk_valid      : chk_data holds a beat (no backpressure)
//   chk_clear      : zeroes chk_err_count
//   chk_locked     : checker is locked to the received sequence
//   chk_err_pulse  : one-cycle pulse per erroneous beat while locked
//   chk_err_count  : saturating count of bit errors seen while locked
// ============================================================================
module oclib_prbs #(
    parameter int WIDTH           = 32,
    parameter int LOCK_COUNT      = 8,
    parameter int UNLOCK_COUNT    = 4,
    parameter int ERR_COUNT_WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [1:0]                 mode,
    input  logic                       gen_enable,
    input  logic                       gen_inject,
    output logic [WIDTH-1:0]           gen_data,
    output logic                       gen_valid,
    input  logic                       gen_ready,
    input  logic [WIDTH-1:0]           chk_data,
    input  logic                       chk_valid,
    input  logic                       chk_clear,
    output logic                       chk_locked,
    output logic                       chk_err_pulse,
    output logic [ERR_COUNT_WIDTH-1:0] chk_err_count
);

    localparam int POP_W = $clog2(WIDTH + 1);
    localparam int SUM_W = ((ERR_COUNT_WIDTH > POP_W) ? ERR_COUNT_WIDTH : POP_W) + 1;
    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W = $clog2(UNLOCK_COUNT + 1);

    localparam logic [RUN_W-1:0]           RUN_LAST = RUN_W'(LOCK_COUNT - 1);
    localparam logic [BAD_W-1:0]           BAD_LAST = BAD_W'(UNLOCK_COUNT - 1);
    localparam logic [ERR_COUNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]                 mode_q;
    logic [30:0]                gen_state_q, gen_state_d;
    logic [WIDTH-1:0]           gen_data_q, gen_data_d;
    logic                       gen_valid_q, gen_valid_d;
    logic [30:0]                chk_hist_q, chk_hist_d;
    state_e                     state_q, state_d;
    logic [RUN_W-1:0]           run_q, run_d;
    logic [BAD_W-1:0]           bad_q, bad_d;
    logic [ERR_COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                       pulse_q, pulse_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [4:0]                 tap_hi;     // n-1
    logic [4:0]                 tap_lo;     // m-1
    logic                       mode_chg;
    logic                       gen_load;
    logic [30:0]                gen_lfsr;
    logic                       gen_fb;
    logic [WIDTH-1:0]           gen_beat;
    logic [30:0]                chk_hist;
    logic                       chk_pred;
    logic [WIDTH-1:0]           chk_err;
    logic [POP_W-1:0]           chk_pop;
    logic [SUM_W-1:0]           cnt_sum;
    logic [ERR_COUNT_WIDTH-1:0] cnt_sat;
    logic                       beat_clean;
    logic                       beat_nonzero;

    assign mode_chg = (mode != mode_q);
    assign gen_load = gen_enable && (!gen_valid_q || gen_ready);

    // Taps always follow the live mode input so that a load on the same
    // edge as a mode change already runs the new polynomial.
    always_comb begin
        tap_hi = 5'd6;
        tap_lo = 5'd5;
        case (mode)
            2'd0:    begin tap_hi = 5'd6;  tap_lo = 5'd5;  end
            2'd1:    begin tap_hi = 5'd14; tap_lo = 5'd13; end
            2'd2:    begin tap_hi = 5'd22; tap_lo = 5'd17; end
            default: begin tap_hi = 5'd30; tap_lo = 5'd27; end
        endcase
    end

    // ------------------------------------------------------------------
    // Generator: advance WIDTH bits from the (possibly reseeded) state
    // ------------------------------------------------------------------
    always_comb begin
        gen_lfsr = mode_chg ? '1 : gen_state_q;
        gen_fb   = 1'b0;
        gen_beat = '0;
        for (int i = 0; i < WIDTH; i++) begin
            gen_fb      = gen_lfsr[tap_hi] ^ gen_lfsr[tap_lo];
            gen_beat[i] = gen_fb;
            gen_lfsr    = {gen_lfsr[29:0], gen_fb};
        end
    end

    always_comb begin
        gen_state_d = mode_chg ? '1 : gen_state_q;
        gen_data_d  = gen_data_q;
        gen_valid_d = gen_valid_q;
        if (gen_load) begin
            gen_state_d   = gen_lfsr;
            gen_data_d    = gen_beat;
            // Injection touches only the output copy; the state stays clean.
            gen_data_d[0] = gen_beat[0] ^ gen_inject;
            gen_valid_d   = 1'b1;
        end else if (gen_ready && !gen_enable) begin
            gen_valid_d   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Checker: predict each bit from the received history, which already
    // contains the earlier bits of the same beat.
    // ------------------------------------------------------------------
    always_comb begin
        chk_hist = chk_hist_q;
        chk_pred = 1'b0;
        chk_err  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            chk_pred   = chk_hist[tap_hi] ^ chk_hist[tap_lo];
            chk_err[i] = chk_pred ^ chk_data[i];
            chk_hist   = {chk_hist[29:0], chk_data[i]};
        end
    end

    always_comb begin
        chk_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            chk_pop = chk_pop + POP_W'(chk_err[i]);
        end
    end

    assign chk_hist_d   = chk_valid ? chk_hist : chk_hist_q;
    assign beat_clean   = (chk_err == '0);
    assign beat_nonzero = |chk_data;
    assign cnt_sum      = SUM_W'(cnt_q) + SUM_W'(chk_pop);
    assign cnt_sat      = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[ERR_COUNT_WIDTH-1:0];

    // ------------------------------------------------------------------
    // Lock FSM and error accounting
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        bad_d   = bad_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (mode_chg) begin
            // A new polynomial invalidates any lock; the error total survives.
            state_d = ST_HUNT;
            run_d   = '0;
            bad_d   = '0;
        end else if (chk_valid) begin
            case (state_q)
                ST_HUNT: begin
                    // An all-zero beat is "clean" against a zero history, so
                    // it must not count towards lock.
                    if (beat_clean && beat_nonzero) begin
                        if (run_q == RUN_LAST) begin
                            state_d = ST_LOCKED;
                            run_d   = '0;
                        end else begin
                            run_d   = run_q + RUN_W'(1);
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!beat_clean) begin
                        cnt_d   = cnt_sat;
                        pulse_d = 1'b1;
                        if (bad_q == BAD_LAST) begin
                            state_d = ST_HUNT;
                            bad_d   = '0;
                        end else begin
                            bad_d   = bad_q + BAD_W'(1);
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
        if (chk_clear) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_q      <= 2'd0;
            gen_state_q <= '1;
            gen_data_q  <= '0;
            gen_valid_q <= 1'b0;
            chk_hist_q  <= '0;
            state_q     <= ST_HUNT;
            run_q       <= '0;
            bad_q       <= '0;
            cnt_q       <= '0;
            pulse_q     <= 1'b0;
        end else begin
            mode_q      <= mode;
            gen_state_q <= gen_state_d;
            gen_data_q  <= gen_data_d;
            gen_valid_q <= gen_valid_d;
            chk_hist_q  <= chk_hist_d;
            state_q     <= state_d;
            run_q       <= run_d;
            bad_q       <= bad_d;
            cnt_q       <= cnt_d;
            pulse_q     <= pulse_d;
        end
    end

    assign gen_data      = gen_data_q;
    assign gen_valid     = gen_valid_q;
    assign chk_locked    = (state_q == ST_LOCKED);
    assign chk_err_pulse = pulse_q;
    assign chk_err_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_oclib_prbs.sv
`default_nettype none
// ============================================================================
// Module   : tb_oclib_prbs
// Purpose  : Self-checking bench for oclib_prbs. A bit-stream reference model
//            (recurrence x[k] = x[k-n] ^ x[k-m] over queues) predicts the
//            generator output and the checker's error/lock behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oclib_prbs;

    localparam int W       = 32;
    localparam int LC      = 8;
    localparam int UC      = 4;
    localparam int ECW     = 4;
    localparam int CNT_MAX = (1 << ECW) - 1;

    logic           clock = 1'b0;
    logic           reset_n;
    logic [1:0]     mode;
    logic           gen_enable;
    logic           gen_inject;
    logic [W-1:0]   gen_data;
    logic           gen_valid;
    logic           gen_ready;
    logic [W-1:0]   chk_data;
    logic           chk_valid;
    logic           chk_clear;
    logic           chk_locked;
    logic           chk_err_pulse;
    logic [ECW-1:0] chk_err_count;

    int checks   = 0;
    int failures = 0;

    oclib_prbs #(
        .WIDTH          (W),
        .LOCK_COUNT     (LC),
        .UNLOCK_COUNT   (UC),
        .ERR_COUNT_WIDTH(ECW)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .mode         (mode),
        .gen_enable   (gen_enable),
        .gen_inject   (gen_inject),
        .gen_data     (gen_data),
        .gen_valid    (gen_valid),
        .gen_ready    (gen_ready),
        .chk_data     (chk_data),
        .chk_valid    (chk_valid),
        .chk_clear    (chk_clear),
        .chk_locked   (chk_locked),
        .chk_err_pulse(chk_err_pulse),
        .chk_err_count(chk_err_count)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    bit         gq[$];      // generated bit stream (seed included), newest last
    bit         rq[$];      // received bit stream, newest last
    logic [1:0] m_mode;
    logic       m_gvalid;
    logic [W-1:0] m_gdata;
    logic       m_locked;
    logic       m_pulse;
    int         m_cnt, m_run, m_bad;
    bit         loopback;

    function automatic int tap_n(input logic [1:0] md);
        case (md)
            2'd0: return 7;
            2'd1: return 15;
            2'd2: return 23;
            default: return 31;
        endcase
    endfunction

    function automatic int tap_m(input logic [1:0] md);
        case (md)
            2'd0: return 6;
            2'd1: return 14;
            2'd2: return 18;
            default: return 28;
        endcase
    endfunction

    task automatic model_reset();
        gq.delete(); rq.delete();
        repeat (31) gq.push_back(1'b1);
        repeat (31) rq.push_back(1'b0);
        m_mode = 2'd0; m_gvalid = 1'b0; m_gdata = '0;
        m_locked = 1'b0; m_pulse = 1'b0;
        m_cnt = 0; m_run = 0; m_bad = 0;
    endtask

    task automatic model_edge();
        bit chg;
        int n, m, e;
        logic [W-1:0] beat;
        chg = (mode !== m_mode);
        n = tap_n(mode);
        m = tap_m(mode);
        beat = '0;
        if (chg) begin
            gq.delete();
            repeat (31) gq.push_back(1'b1);
        end
        if (gen_enable && (!m_gvalid || gen_ready)) begin
            for (int i = 0; i < W; i++) begin
                bit b;
                b = gq[gq.size() - n] ^ gq[gq.size() - m];
                beat[i] = b;
                gq.push_back(b);
                void'(gq.pop_front());
            end
            beat[0]  = beat[0] ^ gen_inject;
            m_gdata  = beat;
            m_gvalid = 1'b1;
        end else if (gen_ready && !gen_enable) begin
            m_gvalid = 1'b0;
        end
        m_pulse = 1'b0;
        if (chk_valid) begin
            e = 0;
            for (int i = 0; i < W; i++) begin
                bit r;
                r = chk_data[i];
                e += int'(r ^ rq[rq.size() - n] ^ rq[rq.size() - m]);
                rq.push_back(r);
                void'(rq.pop_front());
            end
            if (!chg) begin
                if (!m_locked) begin
                    if (e == 0 && chk_data != '0) begin
                        m_run++;
                        if (m_run == LC) begin m_locked = 1'b1; m_run = 0; end
                    end else begin
                        m_run = 0;
                    end
                end else if (e != 0) begin
                    m_cnt   = (m_cnt + e > CNT_MAX) ? CNT_MAX : m_cnt + e;
                    m_pulse = 1'b1;
                    m_bad++;
                    if (m_bad == UC) begin m_locked = 1'b0; m_bad = 0; end
                end else begin
                    m_bad = 0;
                end
            end
        end
        if (chg) begin m_locked = 1'b0; m_run = 0; m_bad = 0; end
        if (chk_clear) m_cnt = 0;
        m_mode = mode;
    endtask

    // One clock: loopback wiring, model update, edge, settle.
    task automatic tick();
        if (loopback) begin
            chk_data  = m_gdata;
            chk_valid = m_gvalid && gen_ready;
        end
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        gen_enable = 1'b0; gen_inject = 1'b0; gen_ready = 1'b0;
        chk_valid = 1'b0; chk_data = '0; chk_clear = 1'b0; loopback = 1'b0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        mode = 2'd0;
        do_reset();
        checks++; if (gen_valid !== 1'b0) begin failures++; $display("FAIL reset_gen_valid got=%b exp=0", gen_valid); end
        checks++; if (gen_data !== '0) begin failures++; $display("FAIL reset_gen_data got=%h exp=0", gen_data); end
        checks++; if (chk_locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", chk_locked); end
        checks++; if (chk_err_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse got=%b exp=0", chk_err_pulse); end
        checks++; if (chk_err_count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", chk_err_count); end
    endtask

    task automatic test_first_beat();
        gen_enable = 1'b1; gen_ready = 1'b1;
        tick();
        checks++; if (gen_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", gen_valid); end
        checks++; if (gen_data[15:0] !== 16'h3040) begin failures++; $display("FAIL first_beat got=%h exp=3040", gen_data[15:0]); end
        checks++; if (gen_data !== m_gdata) begin failures++; $display("FAIL first_beat_model got=%h exp=%h", gen_data, m_gdata); end
        tick();
        checks++; if (gen_data !== m_gdata) begin failures++; $display("FAIL second_beat got=%h exp=%h", gen_data, m_gdata); end
    endtask

    task automatic test_loopback_lock();
        int beats;
        mode = 2'd3;
        do_reset();
        loopback = 1'b1; gen_enable = 1'b1; gen_ready = 1'b1;
        beats = 0;
        for (int c = 0; c < 1020; c++) begin
            tick();
            if (chk_valid) begin
                beats++;
                if (beats == 8) begin
                    checks++; if (chk_locked !== 1'b0) begin failures++; $display("FAIL lock_early got=%b exp=0", chk_locked); end
                end
                if (beats == 9) begin
                    checks++; if (chk_locked !== 1'b1) begin failures++; $display("FAIL lock_by_beat9 got=%b exp=1", chk_locked); end
                end
            end
            checks++; if (gen_data !== m_gdata) begin failures++; $display("FAIL lb_gen_data cyc=%0d got=%h exp=%h", c, gen_data, m_gdata); end
            checks++; if (chk_locked !== m_locked) begin failures++; $display("FAIL lb_locked cyc=%0d got=%b exp=%b", c, chk_locked, m_locked); end
        end
        checks++; if (chk_err_count !== '0) begin failures++; $display("FAIL lb_count got=%0d exp=0", chk_err_count); end
        checks++; if (beats < 1000) begin failures++; $display("FAIL lb_beats got=%0d exp>=1000", beats); end
    endtask

    task automatic test_error_injection();
        int pulses;
        mode = 2'd1;
        tick(); tick();
        for (int c = 0; c < 60 && !chk_locked; c++) tick();
        checks++; if (chk_locked !== 1'b1) begin failures++; $display("FAIL inj_relock got=%b exp=1", chk_locked); end
        chk_clear = 1'b1; tick(); chk_clear = 1'b0;
        gen_inject = 1'b1; tick(); gen_inject = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (chk_err_pulse === 1'b1) pulses++;
        end
        checks++; if (chk_err_count !== 4'd3) begin failures++; $display("FAIL inj_count got=%0d exp=3", chk_err_count); end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL inj_pulses got=%0d exp=1", pulses); end
        checks++; if (chk_locked !== 1'b1) begin failures++; $display("FAIL inj_locked got=%b exp=1", chk_locked); end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 6; k++) begin
            gen_inject = 1'b1; tick(); gen_inject = 1'b0;
            tick(); tick();
        end
        checks++; if (chk_err_count !== ECW'(CNT_MAX)) begin failures++; $display("FAIL sat_count got=%0d exp=%0d", chk_err_count, CNT_MAX); end
        checks++; if (chk_err_count !== ECW'(m_cnt)) begin failures++; $display("FAIL sat_model got=%0d exp=%0d", chk_err_count, m_cnt); end
        checks++; if (chk_locked !== 1'b1) begin failures++; $display("FAIL sat_locked got=%b exp=1", chk_locked); end
    endtask

    task automatic test_clear_concurrent();
        gen_inject = 1'b1; tick(); gen_inject = 1'b0;
        chk_clear = 1'b1; tick(); chk_clear = 1'b0;
        checks++; if (chk_err_count !== '0) begin failures++; $display("FAIL clr_count got=%0d exp=0", chk_err_count); end
        checks++; if (chk_err_pulse !== 1'b1) begin failures++; $display("FAIL clr_pulse got=%b exp=1", chk_err_pulse); end
        tick();
        checks++; if (chk_err_pulse !== 1'b0) begin failures++; $display("FAIL clr_pulse_end got=%b exp=0", chk_err_pulse); end
    endtask

    task automatic test_back_to_back_backpressure();
        logic         hold;
        logic [W-1:0] prev;
        for (int c = 0; c < 400; c++) begin
            gen_ready  = 1'($urandom_range(0, 1));
            gen_enable = ($urandom_range(0, 7) != 0);
            hold = gen_valid && !gen_ready;
            prev = gen_data;
            tick();
            if (hold) begin
                checks++; if (gen_data !== prev) begin failures++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", c, gen_data, prev); end
            end
            checks++; if (gen_valid !== m_gvalid) begin failures++; $display("FAIL bp_valid cyc=%0d got=%b exp=%b", c, gen_valid, m_gvalid); end
            if (m_gvalid) begin
                checks++; if (gen_data !== m_gdata) begin failures++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", c, gen_data, m_gdata); end
            end
        end
        gen_enable = 1'b1; gen_ready = 1'b1;
        checks++; if (chk_err_count !== '0) begin failures++; $display("FAIL bp_count got=%0d exp=0", chk_err_count); end
        checks++; if (chk_locked !== 1'b1) begin failures++; $display("FAIL bp_locked got=%b exp=1", chk_locked); end
    endtask

    task automatic test_mode_change_locked();
        gen_inject = 1'b1; tick(); gen_inject = 1'b0;
        tick(); tick();
        checks++; if (chk_err_count !== 4'd3) begin failures++; $display("FAIL mc_pre_count got=%0d exp=3", chk_err_count); end
        mode = 2'd2;
        tick();
        checks++; if (chk_locked !== 1'b0) begin failures++; $display("FAIL mc_hunt got=%b exp=0", chk_locked); end
        checks++; if (chk_err_count !== 4'd3) begin failures++; $display("FAIL mc_count_kept got=%0d exp=3", chk_err_count); end
        for (int c = 0; c < 40; c++) begin
            tick();
            checks++; if (chk_locked !== m_locked) begin failures++; $display("FAIL mc_locked cyc=%0d got=%b exp=%b", c, chk_locked, m_locked); end
            checks++; if (chk_err_count !== ECW'(m_cnt)) begin failures++; $display("FAIL mc_count cyc=%0d got=%0d exp=%0d", c, chk_err_count, m_cnt); end
        end
        checks++; if (chk_locked !== 1'b1) begin failures++; $display("FAIL mc_relock got=%b exp=1", chk_locked); end
    endtask

    task automatic test_loss();
        loopback = 1'b0; gen_enable = 1'b0; chk_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk_data = W'($urandom());
            tick();
            checks++; if (chk_err_pulse !== m_pulse) begin failures++; $display("FAIL loss_pulse k=%0d got=%b exp=%b", k, chk_err_pulse, m_pulse); end
            checks++; if (chk_locked !== ((k < 4) ? 1'b1 : 1'b0)) begin failures++; $display("FAIL loss_locked k=%0d got=%b exp=%b", k, chk_locked, (k < 4)); end
        end
        checks++; if (chk_err_count !== ECW'(m_cnt)) begin failures++; $display("FAIL loss_count got=%0d exp=%0d", chk_err_count, m_cnt); end
        chk_valid = 1'b0;
    endtask

    task automatic test_all_zero();
        bit ever;
        do_reset();
        chk_valid = 1'b1; chk_data = '0;
        ever = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (chk_locked !== 1'b0) ever = 1'b1;
        end
        checks++; if (ever !== 1'b0) begin failures++; $display("FAIL zero_lock got=1 exp=0"); end
        chk_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        mode = 2'd1;
        loopback = 1'b1; gen_enable = 1'b1; gen_ready = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        gen_inject = 1'b1; tick(); gen_inject = 1'b0; tick();
        checks++; if (chk_err_count === '0) begin failures++; $display("FAIL rm_pre_count got=0 exp=nonzero"); end
        reset_n = 1'b0;
        #2;
        checks++; if (gen_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%b exp=0", gen_valid); end
        checks++; if (gen_data !== '0) begin failures++; $display("FAIL rm_data got=%h exp=0", gen_data); end
        checks++; if (chk_locked !== 1'b0) begin failures++; $display("FAIL rm_locked got=%b exp=0", chk_locked); end
        checks++; if (chk_err_count !== '0) begin failures++; $display("FAIL rm_count got=%0d exp=0", chk_err_count); end
        checks++; if (chk_err_pulse !== 1'b0) begin failures++; $display("FAIL rm_pulse got=%b exp=0", chk_err_pulse); end
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            tick();
            checks++; if (gen_data !== m_gdata) begin failures++; $display("FAIL rm_restart cyc=%0d got=%h exp=%h", c, gen_data, m_gdata); end
        end
        checks++; if (chk_locked !== 1'b1) begin failures++; $display("FAIL rm_relock got=%b exp=1", chk_locked); end
    endtask

    initial begin
        reset_n = 1'b0; mode = 2'd0;
        gen_enable = 1'b0; gen_inject = 1'b0; gen_ready = 1'b0;
        chk_data = '0; chk_valid = 1'b0; chk_clear = 1'b0; loopback = 1'b0;
        model_reset();
        test_reset();
        test_first_beat();
        test_loopback_lock();
        test_error_injection();
        test_saturation();
        test_clear_concurrent();
        test_back_to_back_backpressure();
        test_mode_change_locked();
        test_loss();
        test_all_zero();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/oclib_prbs.md
# oclib_prbs

Parametrised PRBS generator and self-synchronising checker with runtime-selectable polynomial, valid/ready output handshake, lock state machine and saturating error counter. It is the multi-mode successor to the fixed single-polynomial LFSR. It sits at link/SerDes test points: the generator drives a transmit datapath, and the checker monitors the matching receive datapath. Generator and checker may be looped back for self-test.

## Interface
- Width, 32: bits per beat, 1..64; bit 0 is earliest in time.
- LockCount, 8: consecutive clean beats required to lock, ≥1.
- UnlockCount, 4: consecutive erroneous beats while locked that drop lock, ≥1.
- ErrCountWidth, 32: error counter width.
- clock  in  1  sole clock; everything is posedge.
- reset_n  in  1  asynchronous, active-low reset.
- mode  in  2  polynomial select: 0=PRBS7 (taps 7,6), 1=PRBS15 (15,14), 2=PRBS23 (23,18), 3=PRBS31 (31,28).
- gen_enable  in  1  permits generation of new beats.
- gen_inject  in  1  inverts bit 0 of the beat loaded this cycle.
- gen_data  out  Width  generated beat.
- gen_valid  out  1  gen_data is valid.
- gen_ready  in  1  consumer accepts.
- chk_data  in  Width  beat to check.
- chk_valid  in  1  chk_data is valid; there is no backpressure.
- chk_clear  in  1  zeroes chk_err_count.
- chk_locked  out  1  checker is in LOCKED.
- chk_err_pulse  out  1  one-cycle pulse when a LOCKED beat had errors.
- chk_err_count  out  ErrCountWidth  saturating count of bit errors seen while LOCKED.

## Operation
- **Polynomial, Fibonacci form, length n, taps n and m.**
  - Per bit: b = s[n-1] ^ s[m-1].
  - Then s = {s[n-2:0], b}.
  - The emitted bit is b.
  - The sequence is non-inverted.
- **Generator.**
  - State is 31 bits; only the low n bits are used.
  - On reset, or on any change of mode, the low n bits load all-ones.
  - A load happens when gen_enable && (!gen_valid || gen_ready).
  - On a load, the generator advances Width bits, places them in gen_data (bit i = i-th bit generated), and sets gen_valid=1.
  - gen_ready && !gen_enable clears gen_valid.
  - While gen_valid && !gen_ready, gen_data and the state hold.
  - gen_inject affects only the output register, never the state.
- **Checker history.**
  - A 31-bit history holds the last received bits.
  - For each bit i of a chk_valid beat: pred = h[n-1] ^ h[m-1], where the history already includes earlier bits of the same beat.
  - err_i = pred ^ chk_data[i]; the received bit then shifts into h.
  - Beat error count = popcount(err).
  - A single flipped line bit yields exactly 3 error bits (itself, +m, +n).
- **Lock FSM, states HUNT and LOCKED; reset state is HUNT.**
  - HUNT: a clean beat that is not all-zero increments the run counter.
  - HUNT: an erroneous or all-zero beat clears the run counter.
  - HUNT: when the run counter reaches LockCount, go to LOCKED and clear the counter.
  - LOCKED: an erroneous beat adds popcount to chk_err_count (saturating at all-ones), pulses chk_err_pulse, and increments the bad-run counter.
  - LOCKED: a clean beat clears the bad-run counter.
  - LOCKED: when the bad-run counter reaches UnlockCount, go to HUNT.
  - Errors in HUNT are never counted.
- **Mode change.** The checker returns to HUNT, clears the run counters and keeps chk_err_count.
- **chk_clear.** Zeroes chk_err_count. It has priority over a same-cycle increment, so the result is 0.

## Timing
- **Reset values:** gen_valid=0, gen_data=0, chk_locked=0, chk_err_pulse=0, chk_err_count=0, history=0, FSM=HUNT.
- **Generator:**
  - A load sampled at edge k appears on gen_data/gen_valid after edge k.
  - Throughput is one beat per cycle under continuous ready.
- **Checker:**
  - A beat sampled at edge k updates chk_locked, chk_err_pulse and chk_err_count after edge k (latency 1).
  - chk_err_pulse lasts exactly one cycle per erroneous beat.
- **Mode change:** mode is sampled every edge. If it differs from the registered mode, the reseed and checker reset take effect at that edge. A load in the same cycle uses the new seed.
- **Reset mid-operation:** reset_n low clears everything immediately. There is no partial beat.

## Test plan
- **First beat value:** Width=32, mode=0, gen_enable=1, gen_ready=1 after reset → first gen_data[15:0]=16'h3040, gen_valid high the cycle after enable.
- **Loopback lock:** mode=3, gen_data→chk_data with valid→chk_valid → chk_locked=1 no later than 1 cycle after the 9th beat; chk_err_count stays 0 for 1000 beats.
- **Error injection:** locked loopback in mode=1, one gen_inject pulse → chk_err_count +3, exactly one chk_err_pulse, chk_locked stays 1.
- **Backpressure:** gen_ready toggled pseudo-randomly → gen_data stable while valid && !ready; the accepted stream remains error-free at the checker.
- **Loss and false lock:**
  - Locked, then chk_data replaced with random data → chk_locked falls after the 4th erroneous beat.
  - All-zero chk_data for 100 beats → never locks.
- **Boundaries:**
  - chk_clear concurrent with an error → count=0.
  - Counter forced near max (ErrCountWidth=4) → saturates at 15.
  - Mode change while locked → HUNT, count retained.
  - reset_n pulse mid-stream → all outputs return to reset values.
